mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage data-memory access unit; consumes the EX/MEM register outputs (addr, store data, fun_3, r/w strobes).
//  Drives one word-addressed data-cache transaction per load/store with byte enables, waits on cache busywait,
//  aligns/sign-extends load data for MEM/WB, and raises a pipeline-wide busywait stall while an access is in flight.
// PARAMETERS
//  ADDR_W     32   byte address width
//  DATA_W     32   data width; fixed at 32 (byte lanes assume 4)
// PORTS
//  clk               in   1   pipeline clock, rising edge
//  reset             in   1   asynchronous, active-high
//  d_mem_r_in        in   1   load request from EX/MEM register
//  d_mem_w_in        in   1   store request from EX/MEM register
//  fun_3_in          in   3   RV32I width/sign code
//  addr_in           in   32  byte address (ALU result)
//  store_data_in     in   32  unaligned store operand (rs2)
//  dcache_read       out  1   cache read strobe
//  dcache_write      out  1   cache write strobe
//  dcache_addr       out  32  word address {addr_in[31:2],2'b00}
//  dcache_wdata      out  32  store data replicated to lanes
//  dcache_byteen     out  4   write byte enables
//  dcache_rdata      in   32  cache read word
//  dcache_busywait   in   1   cache busy; access done when low in ACCESS
//  busywait          out  1   stall to all pipeline registers
//  load_data_out     out  32  aligned, extended load result
//  misalign_out      out  1   one-cycle pulse: misaligned/illegal access dropped
//  stall_cycles_out  out  32  stall counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): state IDLE; all cache strobes 0, dcache_addr/wdata/byteen 0, busywait 0, load_data_out 0,
//   misalign_out 0, stall_cycles_out 0. Reset mid-access drops strobes immediately; transaction abandoned.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: if exactly one of r/w set and access legal: latch addr/data/byteen/fun_3, strobes 1 next cycle, ->ACCESS.
//    busywait asserted combinationally in IDLE whenever a legal request is present (same-cycle stall).
//   ACCESS: strobes held, busywait 1; on posedge with dcache_busywait==0: capture aligned rdata, strobes 0, ->DONE.
//   DONE: busywait 0 for exactly one cycle; load_data_out valid; pipeline advances at its end; ->IDLE.
//   Minimum load/store latency 3 cycles (IDLE, >=1 ACCESS, DONE); each extra cache busy cycle adds one.
//  fun_3: 000 B(signed), 001 H(signed), 010 W, 100 BU, 101 HU; stores use 000/001/010 only.
//  Legality: H needs addr[0]==0, W needs addr[1:0]==0; reserved fun_3, BU/HU on stores, or r&w both set = illegal.
//   Illegal in IDLE: no cache access, busywait 0, misalign_out=1 for that cycle, load_data_out unchanged.
//  Store lanes: B -> byteen=1<<addr[1:0], wdata={4{d[7:0]}}; H -> byteen=2'b11<<addr[1:0], wdata={2{d[15:0]}};
//   W -> byteen=4'hF. Loads drive byteen=4'h0.
//  Load extract: byte/half selected by addr[1:0]; signed codes sign-extend, U codes zero-extend to 32.
//  Store completion leaves load_data_out unchanged.
// CONFIGURATION
//  DMEM_STALL_COUNT_EN defined: stall_cycles_out counts cycles with busywait==1, saturates at 32'hFFFF_FFFF,
//   cleared only by reset. Undefined: counter logic absent, stall_cycles_out tied to 0.
// STRUCTURE
//  Package mem_pkg: fun_3 localparams (F3_B,F3_H,F3_W,F3_BU,F3_HU), state encoding IDLE/ACCESS/DONE.
//  Sub-module mem_align: combinational store-lane replicate/byteen and load extract/extend; FSM stays in top.
// TESTING
//  LW addr 0x100, cache rdata 0xDEADBEEF, busywait low 1 cycle -> load_data_out 0xDEADBEEF, stall 2 cycles.
//  LB addr 0x103, rdata 0x80AA_BBCC -> 0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr 0x102 -> 0x0000_80AA.
//  SH addr 0x202 data 0x1234_5678 -> byteen 4'b1100, wdata 0x5678_5678, dcache_addr 0x200.
//  LW addr 0x101 -> misalign_out 1 one cycle, no dcache_read, busywait 0.
//  SW with dcache_busywait high 5 cycles, reset asserted cycle 3 -> strobes 0 immediately, state IDLE.
//  DMEM_STALL_COUNT_EN: 3 LW with 2 extra busy cycles each -> stall_cycles_out 12; undefined -> 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the MEM-stage data access unit.
// Holds the RV32I load/store width codes, the FSM encoding and the legality check.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // Exactly one of rd/wr, a known width code, natural alignment.
  function automatic logic access_legal(
    input logic       rd,
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    if (rd ^ wr) begin
      case (f3)
        F3_B:    ok = 1'b1;
        F3_H:    ok = ~off[0];
        F3_W:    ok = (off == 2'b00);
        F3_BU:   ok = rd;
        F3_HU:   ok = rd & ~off[0];
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data cache port.
// Stores replicate into lanes with byte enables; loads extract and extend.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  st_fun_3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [31:0] wdata,
  output logic [3:0]  byteen,
  input  logic [2:0]  ld_fun_3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wdata  = st_data;
    byteen = 4'hF;
    case (st_fun_3)
      F3_B: begin
        wdata  = {4{st_data[7:0]}};
        byteen = 4'b0001 << st_off;
      end
      F3_H: begin
        wdata  = {2{st_data[15:0]}};
        byteen = 4'b0011 << st_off;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = rdata[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_fun_3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-cache access FSM with pipeline stall generation.
// Optional stall-cycle counter enabled by DMEM_STALL_COUNT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_mem_r_in,
  input  logic              d_mem_w_in,
  input  logic [2:0]        fun_3_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] store_data_in,
  output logic              dcache_read,
  output logic              dcache_write,
  output logic [ADDR_W-1:0] dcache_addr,
  output logic [DATA_W-1:0] dcache_wdata,
  output logic [3:0]        dcache_byteen,
  input  logic [DATA_W-1:0] dcache_rdata,
  input  logic              dcache_busywait,
  output logic              busywait,
  output logic [DATA_W-1:0] load_data_out,
  output logic              misalign_out,
  output logic [31:0]       stall_cycles_out
);

  logic [1:0]  state;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_off;
  logic        lat_load;
  logic        req;
  logic        legal;
  logic [31:0] st_wdata;
  logic [3:0]  st_byteen;
  logic [31:0] ld_data;

  assign req   = d_mem_r_in | d_mem_w_in;
  assign legal = access_legal(d_mem_r_in, d_mem_w_in,
                              fun_3_in, addr_in[1:0]);

  // Stall in the request cycle itself so EX/MEM holds the operands.
  assign busywait = ((state == IDLE) && legal) ||
                    (state == ACCESS);
  assign misalign_out = (state == IDLE) && req && !legal;

  mem_align u_align (
    .st_fun_3 (fun_3_in),
    .st_off   (addr_in[1:0]),
    .st_data  (store_data_in),
    .wdata    (st_wdata),
    .byteen   (st_byteen),
    .ld_fun_3 (lat_f3),
    .ld_off   (lat_off),
    .rdata    (dcache_rdata),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      dcache_read   <= 1'b0;
      dcache_write  <= 1'b0;
      dcache_addr   <= '0;
      dcache_wdata  <= '0;
      dcache_byteen <= 4'h0;
      load_data_out <= '0;
      lat_f3        <= 3'b000;
      lat_off       <= 2'b00;
      lat_load      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (legal) begin
            state         <= ACCESS;
            dcache_read   <= d_mem_r_in;
            dcache_write  <= d_mem_w_in;
            dcache_addr   <= {addr_in[ADDR_W-1:2], 2'b00};
            dcache_wdata  <= st_wdata;
            dcache_byteen <= d_mem_w_in ? st_byteen : 4'h0;
            lat_f3        <= fun_3_in;
            lat_off       <= addr_in[1:0];
            lat_load      <= d_mem_r_in;
          end
        end
        ACCESS: begin
          if (!dcache_busywait) begin
            state        <= DONE;
            dcache_read  <= 1'b0;
            dcache_write <= 1'b0;
            if (lat_load) load_data_out <= ld_data;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_STALL_COUNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (busywait && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles_out = stall_cnt;
`else
  assign stall_cycles_out = 32'h0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a load-result scoreboard.
// Stall counter expectations follow DMEM_STALL_COUNT_EN.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_mem_r_in;
  logic        d_mem_w_in;
  logic [2:0]  fun_3_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic        dcache_read;
  logic        dcache_write;
  logic [31:0] dcache_addr;
  logic [31:0] dcache_wdata;
  logic [3:0]  dcache_byteen;
  logic [31:0] dcache_rdata;
  logic        dcache_busywait;
  logic        busywait;
  logic [31:0] load_data_out;
  logic        misalign_out;
  logic [31:0] stall_cycles_out;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_ld  = 32'h0;
  logic [31:0] exp_stall = 32'h0;

  mem_access_unit dut (
    .clk              (clk),
    .reset            (reset),
    .d_mem_r_in       (d_mem_r_in),
    .d_mem_w_in       (d_mem_w_in),
    .fun_3_in         (fun_3_in),
    .addr_in          (addr_in),
    .store_data_in    (store_data_in),
    .dcache_read      (dcache_read),
    .dcache_write     (dcache_write),
    .dcache_addr      (dcache_addr),
    .dcache_wdata     (dcache_wdata),
    .dcache_byteen    (dcache_byteen),
    .dcache_rdata     (dcache_rdata),
    .dcache_busywait  (dcache_busywait),
    .busywait         (busywait),
    .load_data_out    (load_data_out),
    .misalign_out     (misalign_out),
    .stall_cycles_out (stall_cycles_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input string tag);
`ifdef DMEM_STALL_COUNT_EN
    chk(tag, stall_cycles_out, exp_stall);
`else
    chk(tag, stall_cycles_out, 32'h0);
`endif
  endtask

  task automatic access(input logic r, input logic w,
                        input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input int busy,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] exp_ld);
    logic [31:0] exp_addr;
    logic [31:0] got;
    exp_addr = {a[31:2], 2'b00};
    @(negedge clk);
    d_mem_r_in = r;
    d_mem_w_in = w;
    fun_3_in = f3;
    addr_in = a;
    store_data_in = d;
    dcache_rdata = rd;
    dcache_busywait = 1'b1;
    #1;
    chk("idle_busywait", {31'h0, busywait}, 32'h1);
    chk("idle_no_strobe", {30'h0, dcache_read, dcache_write}, 32'h0);
    exp_q.push_back(r ? exp_ld : last_ld);
    @(posedge clk);
    for (int k = 0; k <= busy; k++) begin
      @(negedge clk);
      dcache_busywait = (k < busy);
      chk("acc_read", {31'h0, dcache_read}, {31'h0, r});
      chk("acc_write", {31'h0, dcache_write}, {31'h0, w});
      chk("acc_busywait", {31'h0, busywait}, 32'h1);
      if (k == 0) begin
        chk("acc_addr", dcache_addr, exp_addr);
        chk("acc_byteen", {28'h0, dcache_byteen}, {28'h0, be});
        if (w) chk("acc_wdata", dcache_wdata, wd);
      end
      @(posedge clk);
    end
    exp_stall = exp_stall + 32'(busy + 2);
    @(negedge clk);
    chk("done_busywait", {31'h0, busywait}, 32'h0);
    chk("done_strobes", {30'h0, dcache_read, dcache_write}, 32'h0);
    got = exp_q.pop_front();
    chk("load_data", load_data_out, got);
    last_ld = got;
    chk_stall("stall_cnt");
    @(posedge clk);
    #1;
    d_mem_r_in = 1'b0;
    d_mem_w_in = 1'b0;
  endtask

  task automatic illegal(input logic r, input logic w,
                         input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    d_mem_r_in = r;
    d_mem_w_in = w;
    fun_3_in = f3;
    addr_in = a;
    #1;
    chk("ill_misalign", {31'h0, misalign_out}, 32'h1);
    chk("ill_busywait", {31'h0, busywait}, 32'h0);
    @(posedge clk);
    #1;
    d_mem_r_in = 1'b0;
    d_mem_w_in = 1'b0;
    @(negedge clk);
    chk("ill_no_strobe", {30'h0, dcache_read, dcache_write}, 32'h0);
    chk("ill_misalign_end", {31'h0, misalign_out}, 32'h0);
    chk("ill_load_keep", load_data_out, last_ld);
  endtask

  initial begin
    reset = 1'b1;
    d_mem_r_in = 1'b0;
    d_mem_w_in = 1'b0;
    fun_3_in = 3'b000;
    addr_in = 32'h0;
    store_data_in = 32'h0;
    dcache_rdata = 32'h0;
    dcache_busywait = 1'b0;
    #12;
    chk("rst_strobes", {30'h0, dcache_read, dcache_write}, 32'h0);
    chk("rst_addr", dcache_addr, 32'h0);
    chk("rst_wdata", dcache_wdata, 32'h0);
    chk("rst_byteen", {28'h0, dcache_byteen}, 32'h0);
    chk("rst_busywait", {31'h0, busywait}, 32'h0);
    chk("rst_load", load_data_out, 32'h0);
    chk("rst_misalign", {31'h0, misalign_out}, 32'h0);
    chk("rst_stall", stall_cycles_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
           4'h0, 32'h0, 32'hDEADBEEF);
    access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 1,
           4'h0, 32'h0, 32'hFFFFFF80);
    access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80AABBCC, 0,
           4'h0, 32'h0, 32'h00000080);
    access(1, 0, 3'b101, 32'h102, 32'h0, 32'h80AABBCC, 0,
           4'h0, 32'h0, 32'h000080AA);
    access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80AABBCC, 0,
           4'h0, 32'h0, 32'hFFFF80AA);
    access(1, 0, 3'b000, 32'h101, 32'h0, 32'h80AABBCC, 0,
           4'h0, 32'h0, 32'hFFFFFFBB);
    access(0, 1, 3'b001, 32'h202, 32'h12345678, 32'h0, 0,
           4'b1100, 32'h56785678, 32'h0);
    access(0, 1, 3'b000, 32'h201, 32'h12345678, 32'h0, 2,
           4'b0010, 32'h78787878, 32'h0);
    access(0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 0,
           4'b1111, 32'hCAFEF00D, 32'h0);

    illegal(1, 0, 3'b010, 32'h101);
    illegal(1, 0, 3'b001, 32'h103);
    illegal(0, 1, 3'b100, 32'h200);
    illegal(1, 1, 3'b010, 32'h200);
    illegal(1, 0, 3'b011, 32'h200);
    chk_stall("stall_after_illegal");

    @(negedge clk);
    d_mem_w_in = 1'b1;
    fun_3_in = 3'b010;
    addr_in = 32'h400;
    store_data_in = 32'hAAAA5555;
    dcache_busywait = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_write1", {31'h0, dcache_write}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_write2", {31'h0, dcache_write}, 32'h1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    d_mem_w_in = 1'b0;
    #1;
    chk("rst_mid_strobe", {30'h0, dcache_read, dcache_write}, 32'h0);
    chk("rst_mid_busywait", {31'h0, busywait}, 32'h0);
    chk("rst_mid_byteen", {28'h0, dcache_byteen}, 32'h0);
    chk("rst_mid_load", load_data_out, 32'h0);
    chk("rst_mid_stall", stall_cycles_out, 32'h0);
    last_ld = 32'h0;
    exp_stall = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    dcache_busywait = 1'b0;

    for (int i = 0; i < 3; i++) begin
      access(1, 0, 3'b010, 32'h500 + 32'(4 * i), 32'h0,
             32'h11110000 + 32'(i), 2, 4'h0, 32'h0,
             32'h11110000 + 32'(i));
    end
`ifdef DMEM_STALL_COUNT_EN
    chk("stall_total", stall_cycles_out, 32'd12);
`else
    chk("stall_total", stall_cycles_out, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
